// File: rtl/dir_input_scheduler.sv
// Direction input scheduler for a snake-style game.
// Edge-detects four direction buttons, filters illegal turns and queues up to two
// pending directions. Each game tick applies the oldest pending direction.
// Optional feature: define DIR_PAUSE_EN to add a btn_pause input and a paused
// output. In PAUSED, ticks are ignored and direction presses are still queued.
module dir_input_scheduler #(
    parameter logic [1:0] INIT_DIR = 2'b11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       tick,
`ifdef DIR_PAUSE_EN
    input  logic       btn_pause,
    output logic       paused,
`endif
    output logic [1:0] dir_out,
    output logic       dir_valid,
    output logic [1:0] q_count,
    output logic       drop
);

    // Direction encoding: 00 up, 01 down, 10 left, 11 right.
    localparam logic [1:0] DirUp    = 2'b00;
    localparam logic [1:0] DirDown  = 2'b01;
    localparam logic [1:0] DirLeft  = 2'b10;
    localparam logic [1:0] DirRight = 2'b11;

    // Button vector order: [3] up, [2] down, [1] left, [0] right.
    logic [3:0] levels;
    logic [3:0] prev_q;
    logic [3:0] press;

    // Two-entry FIFO: q0 is the head, q1 is only meaningful when two are pending.
    logic [1:0] q0_q, q0_d;
    logic [1:0] q1_q, q1_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] dir_q;
    logic       valid_q;
    logic       drop_q;

    logic       win_valid;
    logic [1:0] win_dir;
    logic [1:0] ref_dir;
    logic       reject;
    logic       tick_eff;
    logic       pop;
    logic       push;

    assign levels = {btn_up, btn_down, btn_left, btn_right};
    assign press  = levels & ~prev_q;

`ifdef DIR_PAUSE_EN
    localparam logic [0:0] StRun    = 1'b0;
    localparam logic [0:0] StPaused = 1'b1;

    logic [0:0] state_q, state_d;
    logic       pause_prev_q;
    logic       pause_press;

    assign pause_press = btn_pause & ~pause_prev_q;

    // A pause edge takes effect before the same-cycle tick is considered.
    always_comb begin
        state_d = state_q;
        if (pause_press) begin
            state_d = (state_q == StRun) ? StPaused : StRun;
        end
    end

    assign tick_eff = tick & (state_d == StRun);
    assign paused   = (state_q == StPaused);

    // Pause state machine and its edge-detector history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            pause_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            pause_prev_q <= btn_pause;
        end
    end
`else
    assign tick_eff = tick;
`endif

    // Fixed-priority winner among simultaneous presses: up > down > left > right.
    always_comb begin
        win_valid = |press;
        win_dir   = DirRight;
        if (press[3]) begin
            win_dir = DirUp;
        end else if (press[2]) begin
            win_dir = DirDown;
        end else if (press[1]) begin
            win_dir = DirLeft;
        end
    end

    // Turns are judged against the newest queued direction, before any pop.
    always_comb begin
        ref_dir = dir_q;
        if (cnt_q == 2'd2) begin
            ref_dir = q1_q;
        end else if (cnt_q == 2'd1) begin
            ref_dir = q0_q;
        end
    end

    // Opposites share bit[1] and differ in bit[0].
    assign reject = (win_dir == ref_dir)
                 || ((win_dir[1] == ref_dir[1]) && (win_dir[0] != ref_dir[0]))
                 || ((cnt_q == 2'd2) && !tick_eff);

    assign pop  = tick_eff && (cnt_q != 2'd0);
    assign push = win_valid && !reject;

    // FIFO next state: pop first, then append behind whatever remains.
    always_comb begin
        q0_d  = q0_q;
        q1_d  = q1_q;
        cnt_d = cnt_q;
        if (pop) begin
            q0_d  = q1_q;
            cnt_d = cnt_q - 2'd1;
        end
        if (push) begin
            if (cnt_d == 2'd0) begin
                q0_d = win_dir;
            end else begin
                q1_d = win_dir;
            end
            cnt_d = cnt_d + 2'd1;
        end
    end

    // Registered state: button history, FIFO, applied direction and pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= 4'b1111;
            q0_q    <= 2'b00;
            q1_q    <= 2'b00;
            cnt_q   <= 2'd0;
            dir_q   <= INIT_DIR;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            prev_q  <= levels;
            q0_q    <= q0_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            valid_q <= pop;
            drop_q  <= win_valid && reject;
            if (pop) begin
                dir_q <= q0_q;
            end
        end
    end

    assign dir_out   = dir_q;
    assign dir_valid = valid_q;
    assign q_count   = cnt_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_dir_input_scheduler.sv
// Self-checking bench for dir_input_scheduler: a queue-based model checked every
// cycle, plus literal expectations at key points. Pause scenario runs only when
// DIR_PAUSE_EN is defined.
module tb_dir_input_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] dir_out;
    logic       dir_valid;
    logic [1:0] q_count;
    logic       drop;
`ifdef DIR_PAUSE_EN
    logic       btn_pause = 1'b0;
    logic       paused;
`endif

    int checks = 0;
    int errors = 0;

    dir_input_scheduler #(.INIT_DIR(2'b11)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .tick      (tick),
`ifdef DIR_PAUSE_EN
        .btn_pause (btn_pause),
        .paused    (paused),
`endif
        .dir_out   (dir_out),
        .dir_valid (dir_valid),
        .q_count   (q_count),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    // Behavioural model
    logic [1:0] m_dir;
    logic [1:0] mq[$];
    bit         m_valid, m_drop, m_paused, m_pprev, m_live;
    bit   [3:0] m_prev, m_lv, m_pr;
    bit         m_tick, m_full;
    logic [1:0] m_ref, m_win;

    always @(posedge clk) begin
        if (rst) begin
            m_dir = 2'b11; mq.delete(); m_valid = 0; m_drop = 0;
            m_prev = 4'hf; m_paused = 0; m_pprev = 1; m_live = 1;
        end else begin
            m_lv = {btn_up, btn_down, btn_left, btn_right};
            m_pr = m_lv & ~m_prev;
            m_prev = m_lv;
`ifdef DIR_PAUSE_EN
            if (btn_pause && !m_pprev) m_paused = !m_paused;
            m_pprev = btn_pause;
`endif
            m_tick = tick && !m_paused;
            m_ref  = (mq.size() > 0) ? mq[$] : m_dir;
            m_full = (mq.size() == 2) && !m_tick;
            m_valid = 0; m_drop = 0;
            if (m_tick && mq.size() > 0) begin
                m_dir = mq.pop_front();
                m_valid = 1;
            end
            if (m_pr != 0) begin
                m_win = m_pr[3] ? 2'd0 : m_pr[2] ? 2'd1 : m_pr[1] ? 2'd2 : 2'd3;
                if (m_win == m_ref || (m_win ^ m_ref) == 2'b01 || m_full) m_drop = 1;
                else mq.push_back(m_win);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            checks++;
            if (dir_out !== m_dir || dir_valid !== m_valid || drop !== m_drop
                || q_count !== 2'(mq.size())) begin
                errors++;
                $display("FAIL model t=%0t got dir=%b v=%b drop=%b q=%0d want dir=%b v=%b drop=%b q=%0d",
                         $time, dir_out, dir_valid, drop, q_count, m_dir, m_valid, m_drop,
                         mq.size());
            end
`ifdef DIR_PAUSE_EN
            checks++;
            if (paused !== m_paused) begin
                errors++;
                $display("FAIL model_paused t=%0t got %b want %b", $time, paused, m_paused);
            end
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [1:0] d, input logic v,
                       input logic [1:0] q, input logic dr);
        checks++;
        if (dir_out !== d || dir_valid !== v || q_count !== q || drop !== dr) begin
            errors++;
            $display("FAIL %s got dir=%b v=%b q=%0d drop=%b want dir=%b v=%b q=%0d drop=%b",
                     name, dir_out, dir_valid, q_count, drop, d, v, q, dr);
        end
    endtask

    task automatic do_reset();
        rst = 1; cyc(); cyc(); rst = 0; cyc();
    endtask

    initial begin
        // Reset with right held, then tick
        btn_right = 1;
        do_reset();
        lit("reset", 2'b11, 0, 0, 0);
        tick = 1; cyc(); tick = 0;
        lit("held_right_tick", 2'b11, 0, 0, 0);
        btn_right = 0; cyc();

        // up, left queued, then three ticks
        btn_up = 1; cyc(); btn_up = 0;
        lit("push_up", 2'b11, 0, 1, 0);
        btn_left = 1; cyc(); btn_left = 0;
        lit("push_left", 2'b11, 0, 2, 0);
        tick = 1; cyc();
        lit("tick1", 2'b00, 1, 1, 0);
        cyc();
        lit("tick2", 2'b10, 1, 0, 0);
        cyc(); tick = 0;
        lit("tick3", 2'b10, 0, 0, 0);
        cyc();

        // Rejections from dir 11
        do_reset();
        btn_left = 1; cyc(); btn_left = 0;
        lit("drop_opposite", 2'b11, 0, 0, 1);
        btn_right = 1; cyc(); btn_right = 0;
        lit("drop_same", 2'b11, 0, 0, 1);
        btn_up = 1; cyc(); btn_up = 0;
        lit("accept_up", 2'b11, 0, 1, 0);
        btn_down = 1; cyc(); btn_down = 0;
        lit("drop_opp_tail", 2'b11, 0, 1, 1);
        cyc();

        // Full queue
        btn_left = 1; cyc(); btn_left = 0;
        lit("fill", 2'b11, 0, 2, 0);
        btn_down = 1; cyc(); btn_down = 0;
        lit("drop_full", 2'b11, 0, 2, 1);
        cyc();
        btn_down = 1; tick = 1; cyc(); btn_down = 0; tick = 0;
        lit("full_with_tick", 2'b00, 1, 2, 0);
        tick = 1; cyc();
        lit("pop_left", 2'b10, 1, 1, 0);
        cyc(); tick = 0;
        lit("pop_down", 2'b01, 1, 0, 0);

        // Simultaneous up and left
        do_reset();
        btn_up = 1; btn_left = 1; cyc(); btn_up = 0; btn_left = 0;
        lit("priority", 2'b11, 0, 1, 0);

        // Empty-queue press with tick: applied only on the following tick
        tick = 1; cyc(); tick = 0;
        lit("apply_up", 2'b00, 1, 0, 0);
        btn_right = 1; tick = 1; cyc(); btn_right = 0; tick = 0;
        lit("same_cycle_push", 2'b00, 0, 1, 0);
        tick = 1; cyc(); tick = 0;
        lit("next_tick", 2'b11, 1, 0, 0);

        // Mid-operation reset with press and tick held
        btn_up = 1; cyc(); btn_up = 0; cyc();
        rst = 1; tick = 1; btn_down = 1; cyc(); rst = 0; tick = 0;
        lit("mid_reset", 2'b11, 0, 0, 0);
        cyc();
        lit("held_after_reset", 2'b11, 0, 0, 0);
        btn_down = 0; cyc();

`ifdef DIR_PAUSE_EN
        btn_pause = 1; cyc(); btn_pause = 0;
        btn_up = 1; cyc(); btn_up = 0;
        tick = 1; cyc(); tick = 0;
        lit("paused_tick", 2'b11, 0, 1, 0);
        checks++;
        if (paused !== 1'b1) begin
            errors++;
            $display("FAIL paused_on got %b want 1", paused);
        end
        btn_pause = 1; tick = 1; cyc(); btn_pause = 0; tick = 0;
        lit("resume_tick", 2'b00, 1, 0, 0);
        checks++;
        if (paused !== 1'b0) begin
            errors++;
            $display("FAIL paused_off got %b want 0", paused);
        end
`endif
        cyc(); cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dir_input_scheduler.md
DIR_INPUT_SCHEDULER -- requirements
Module: dir_input_scheduler

Interface
REQ-001 Parameter: INIT_DIR, default 2'b11, direction loaded into dir_out at reset (00 up, 01 down, 10 left, 11 right).
REQ-002 clk  input  1  system clock; all logic on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 btn_up, btn_down, btn_left, btn_right  input  1 each  debounced button levels, high = pressed.
REQ-005 tick  input  1  one-cycle game-step strobe.
REQ-006 dir_out  output  2  direction currently applied to the snake.
REQ-007 dir_valid  output  1  one-cycle pulse, high in the cycle after a tick that changed dir_out.
REQ-008 q_count  output  2  pending-command count, 0..2.
REQ-009 drop  output  1  one-cycle pulse, high in the cycle after a press was rejected.

Function
REQ-010 Each button SHALL pass through a rising-edge detector: press = level AND NOT previous level.
REQ-011 Simultaneous presses in one cycle SHALL be resolved by fixed priority up > down > left > right; only the winner is evaluated and the losers are discarded without asserting drop.
REQ-012 The reference direction SHALL be the newest queue entry when q_count > 0, otherwise dir_out, taken before any same-cycle pop.
REQ-013 A winning press SHALL be rejected (drop=1) if it equals the reference, or is opposite to it (same bit[1], different bit[0]).
REQ-014 A press SHALL also be rejected (drop=1) if q_count == 2 and tick is low.
REQ-015 A press otherwise SHALL be pushed into a 2-entry FIFO.
REQ-016 On tick with q_count > 0, the head SHALL be popped into dir_out and dir_valid SHALL be 1 on the next cycle.
REQ-017 On tick with q_count == 0, dir_out SHALL hold and dir_valid SHALL stay 0.
REQ-018 Tick and push in the same cycle SHALL pop first, then push, with net q_count change = push - pop.
REQ-019 A press pushed in the same cycle as a tick SHALL NOT reach dir_out before the following tick.
REQ-020 Minimum press-to-dir_out latency SHALL be 2 cycles: press registered, then tick.
REQ-021 q_count SHALL never exceed 2 or underflow below 0.

Reset
REQ-022 On rst: dir_out=INIT_DIR, q_count=0, queue contents cleared, dir_valid=0, drop=0.
REQ-023 On rst: all previous-level registers SHALL be set to 1, so buttons held through reset produce no press until released and re-pressed.
REQ-024 A rst asserted mid-operation SHALL discard pending entries and suppress any same-cycle tick or press.

Configuration
REQ-025 Macro DIR_PAUSE_EN SHALL enable an additional input btn_pause (1 bit, debounced) and output paused (1 bit, reset 0).
REQ-026 With DIR_PAUSE_EN, a btn_pause rising edge SHALL toggle a RUN/PAUSED state machine.
REQ-027 In PAUSED, tick SHALL be ignored (no pop, no dir_valid), while direction presses continue to be queued per REQ-013..015.
REQ-028 In PAUSED, paused SHALL be 1.
REQ-029 A btn_pause edge in the same cycle as a tick SHALL take effect first, so the tick is ignored when entering PAUSED and honored when leaving PAUSED.
REQ-030 Without DIR_PAUSE_EN, the port, state machine and paused output SHALL be absent, and behaviour SHALL be as in REQ-010..024.

Verification
REQ-031 Reset with btn_right held, then tick -> dir_out=11, q_count=0, dir_valid=0, drop=0.
REQ-032 From dir_out=11: press up, then press left, then 3 ticks -> dir_out 00 then 10, dir_valid pulses twice, q_count 2->1->0, third tick gives no pulse.
REQ-033 From dir_out=11: press left -> drop=1, q_count=0. Press right -> drop=1. Press up then down -> down dropped (opposite of tail 00).
REQ-034 Queue full (up, left from dir_out=11): press down with tick low -> drop=1. Press down in the same cycle as tick -> accepted, q_count stays 2.
REQ-035 up and left rising in the same cycle from dir_out=11 -> only up queued, drop=0, q_count=1.
REQ-036 With DIR_PAUSE_EN: pause edge, press up, tick -> dir_out unchanged, q_count=1, paused=1. Pause edge again, tick -> dir_out=00, paused=0.
